// File: rtl/motor_ramp_if.sv
// Bundle between the mode/decision logic and the two-motor ramp controller.
// Ports: mode (drive request, 3b) in; left/right duty (10b), l_IN/r_IN bridge
// codes (2b), busy, state (2b debug) out of the controller.
interface motor_ramp_if;
  logic [2:0] mode;
  logic [9:0] left_duty;
  logic [9:0] right_duty;
  logic [1:0] l_IN;
  logic [1:0] r_IN;
  logic       busy;
  logic [1:0] state;

  // Decision logic side: drives the request, observes the outputs.
  modport master (
    output mode,
    input  left_duty, right_duty, l_IN, r_IN, busy, state
  );

  // Controller side.
  modport slave (
    input  mode,
    output left_duty, right_duty, l_IN, r_IN, busy, state
  );
endinterface

// File: rtl/motor_ramp_ctrl.sv
// Purpose: slew-limited duty sequencing for two motors with brake/dead-time
//          on direction reversal. All outputs registered; duties move only on
//          ramp ticks (every TICK_DIV clks), bridge codes change on state entry.
// Ports:   clk, rst (async, active-high); bus.mode in; bus.left_duty/right_duty,
//          bus.l_IN/r_IN, bus.busy, bus.state out.
module motor_ramp_ctrl #(
  parameter int TICK_DIV   = 100000,
  parameter int STEP       = 16,
  parameter int DEAD_TICKS = 50,
  parameter int DUTY_HI    = 800,
  parameter int DUTY_TRIM  = 780,
  parameter int DUTY_LO    = 750
) (
  input  logic         clk,
  input  logic         rst,
  motor_ramp_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BRAKE = 2'd2, DEAD = 2'd3} state_e;
  typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_FWD = 2'd1, DIR_REV = 2'd2} dir_e;

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEAD_TICKS > 0) ? $clog2(DEAD_TICKS + 1) : 1;

  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_TICKS);
  localparam logic [9:0]    STEP_V    = 10'(STEP);
  localparam logic [9:0]    HI_V      = 10'(DUTY_HI);
  localparam logic [9:0]    TRIM_V    = 10'(DUTY_TRIM);
  localparam logic [9:0]    LO_V      = 10'(DUTY_LO);

  state_e        st_q;
  dir_e          dir_q;
  logic [CW-1:0] cnt_q;
  logic [DW-1:0] dead_q;
  logic [9:0]    left_q, right_q;
  logic [1:0]    bridge_q;
  logic          busy_q;

  logic          tick;
  dir_e          dir_req;
  logic [9:0]    dec_l, dec_r;
  logic [9:0]    tgt_l, tgt_r;
  logic [9:0]    next_l, next_r;

  // One step toward tgt using the difference form, so no overshoot or wrap.
  function automatic logic [9:0] slew(input logic [9:0] cur, input logic [9:0] tgt);
    logic [9:0] d;
    if (cur < tgt) begin
      d = tgt - cur;
      slew = (d > STEP_V) ? cur + STEP_V : tgt;
    end else if (cur > tgt) begin
      d = cur - tgt;
      slew = (d > STEP_V) ? cur - STEP_V : tgt;
    end else begin
      slew = cur;
    end
  endfunction

  function automatic logic [1:0] bridge_code(input dir_e d);
    bridge_code = (d == DIR_REV) ? 2'b01 : 2'b10;
  endfunction

  assign tick = (cnt_q == TICK_LAST);

  // Mode decode: low bits pick the wheel pair, bit 2 picks reverse.
  always_comb begin
    dir_req = DIR_NONE;
    dec_l   = '0;
    dec_r   = '0;
    case (bus.mode[1:0])
      2'b01:   begin dec_l = HI_V; dec_r = TRIM_V; end
      2'b10:   begin dec_l = LO_V; dec_r = HI_V;   end
      2'b11:   begin dec_l = HI_V; dec_r = LO_V;   end
      default: begin dec_l = '0;   dec_r = '0;     end
    endcase
    if (bus.mode[1:0] != 2'b00)
      dir_req = bus.mode[2] ? DIR_REV : DIR_FWD;
  end

  // Ramp target: the decoded pair only while the request matches the latched
  // direction; anything else (stop, reversal, brake) ramps toward zero. A
  // brake abort on a tick cycle therefore already steps toward the new pair.
  always_comb begin
    tgt_l = '0;
    tgt_r = '0;
    if ((st_q == RUN || st_q == BRAKE) && dir_req == dir_q) begin
      tgt_l = dec_l;
      tgt_r = dec_r;
    end
  end

  assign next_l = tick ? slew(left_q, tgt_l)  : left_q;
  assign next_r = tick ? slew(right_q, tgt_r) : right_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= IDLE;
      dir_q    <= DIR_FWD;
      cnt_q    <= '0;
      dead_q   <= '0;
      left_q   <= '0;
      right_q  <= '0;
      bridge_q <= 2'b00;
      busy_q   <= 1'b0;
    end else begin
      cnt_q  <= tick ? '0 : cnt_q + 1'b1;
      busy_q <= (st_q == BRAKE) || (st_q == DEAD) ||
                (st_q == RUN && (left_q != tgt_l || right_q != tgt_r));

      case (st_q)
        IDLE: begin
          left_q  <= '0;
          right_q <= '0;
          if (dir_req != DIR_NONE) begin
            dir_q    <= dir_req;
            bridge_q <= bridge_code(dir_req);
            st_q     <= RUN;
          end
        end

        RUN: begin
          left_q  <= next_l;
          right_q <= next_r;
          if (dir_req == DIR_NONE) begin
            if (tick && next_l == '0 && next_r == '0) begin
              bridge_q <= 2'b00;
              st_q     <= IDLE;
            end
          end else if (dir_req != dir_q) begin
            st_q <= BRAKE;
          end
        end

        BRAKE: begin
          left_q  <= next_l;
          right_q <= next_r;
          if (dir_req == dir_q) begin
            st_q <= RUN;
          end else if (next_l == '0 && next_r == '0) begin
            // Bridges go off in the same edge the duties land on zero.
            bridge_q <= 2'b00;
            dead_q   <= DEAD_LOAD;
            st_q     <= DEAD;
          end
        end

        DEAD: begin
          left_q  <= '0;
          right_q <= '0;
          if (tick) begin
            if (dead_q <= DW'(1)) begin
              dead_q <= '0;
              if (dir_req == DIR_NONE) begin
                st_q <= IDLE;
              end else begin
                dir_q    <= dir_req;
                bridge_q <= bridge_code(dir_req);
                st_q     <= RUN;
              end
            end else begin
              dead_q <= dead_q - 1'b1;
            end
          end
        end

        default: st_q <= IDLE;
      endcase
    end
  end

  assign bus.left_duty  = left_q;
  assign bus.right_duty = right_q;
  assign bus.l_IN       = bridge_q;
  assign bus.r_IN       = bridge_q;
  assign bus.busy       = busy_q;
  assign bus.state      = st_q;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl with TICK_DIV=4, STEP=100, DEAD_TICKS=2.
// Edge numbers in comments (E<n>) count rising clk edges since reset release;
// with the tick counter starting at 0, ramp ticks land on E4, E8, E12, ...
module tb_motor_ramp_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  motor_ramp_if bus ();

  motor_ramp_ctrl #(
    .TICK_DIV(4), .STEP(100), .DEAD_TICKS(2),
    .DUTY_HI(800), .DUTY_TRIM(780), .DUTY_LO(750)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int st, input int bridge,
                         input int ld, input int rd);
    chk({tag, ".state"}, 32'(bus.state), st);
    chk({tag, ".l_IN"}, 32'(bus.l_IN), bridge);
    chk({tag, ".r_IN"}, 32'(bus.r_IN), bridge);
    chk({tag, ".left"}, 32'(bus.left_duty), ld);
    chk({tag, ".right"}, 32'(bus.right_duty), rd);
  endtask

  // Bridge safety: no direct 10<->01 swap, no duty under a 00 bridge.
  logic [1:0] prev_in = 2'b00;
  always @(negedge clk) begin
    if (!rst) begin
      assert (!((prev_in == 2'b10 && bus.l_IN == 2'b01) || (prev_in == 2'b01 && bus.l_IN == 2'b10)))
      else begin
        fails++;
        $error("FAIL inv_swap observed=%0b expected=no direct swap from %0b", bus.l_IN, prev_in);
      end
      assert (!(bus.l_IN == 2'b00 && (bus.left_duty != 0 || bus.right_duty != 0)))
      else begin
        fails++;
        $error("FAIL inv_duty_off observed=%0d/%0d expected=0/0 with bridge 00",
               bus.left_duty, bus.right_duty);
      end
    end
    prev_in = bus.l_IN;
  end

  initial begin
    bus.mode = 3'b000;

    // Reset state while rst held.
    step(3);
    chk_all("rst_hold", 0, 0, 0, 0);
    chk("rst_hold.busy", 32'(bus.busy), 0);

    // Start forward: release reset and request 001 together (E0).
    rst = 1'b0;
    bus.mode = 3'b001;
    step(1);                         // E1
    chk_all("start", 1, 2'b10, 0, 0);
    step(3);                         // E4 first tick
    chk_all("ramp1", 1, 2'b10, 100, 100);
    for (int k = 2; k <= 8; k++) begin
      step(4);                       // E4k
      chk($sformatf("ramp%0d.left", k), 32'(bus.left_duty), 100 * k);
      chk($sformatf("ramp%0d.right", k), 32'(bus.right_duty), (100 * k > 780) ? 780 : 100 * k);
    end
    chk("ramp_done.busy", 32'(bus.busy), 1);   // E32: right just reached 780
    step(1);                                   // E33
    chk("ramp_idle.busy", 32'(bus.busy), 0);

    // Turn at speed: left turn targets 750/800.
    bus.mode = 3'b010;
    step(2);                         // E35, no tick yet
    chk_all("turn_pre", 1, 2'b10, 800, 780);
    step(1);                         // E36 tick
    chk_all("turn", 1, 2'b10, 750, 800);

    // Back to straight, then reverse.
    bus.mode = 3'b001;
    step(4);                         // E40
    chk_all("straight", 1, 2'b10, 800, 780);
    bus.mode = 3'b101;
    step(1);                         // E41
    chk_all("brake_entry", 2, 2'b10, 800, 780);
    step(3);                         // E44
    chk_all("brake1", 2, 2'b10, 700, 680);
    step(24);                        // E68
    chk_all("brake7", 2, 2'b10, 100, 80);
    step(4);                         // E72
    chk_all("dead_entry", 3, 0, 0, 0);
    chk("dead_entry.busy", 32'(bus.busy), 1);
    step(4);                         // E76 first dead tick
    chk_all("dead1", 3, 0, 0, 0);
    step(4);                         // E80 second dead tick: exit
    chk_all("rev_run", 1, 2'b01, 0, 0);
    step(4);                         // E84
    chk_all("rev1", 1, 2'b01, 100, 100);
    step(28);                        // E112
    chk_all("rev8", 1, 2'b01, 800, 780);

    // Abort brake (mirrored in reverse): oppose, then return at 500/480.
    bus.mode = 3'b001;
    step(1);                         // E113
    chk_all("abort_brake", 2, 2'b01, 800, 780);
    step(11);                        // E124
    chk_all("abort_mid", 2, 2'b01, 500, 480);
    bus.mode = 3'b101;
    step(1);                         // E125
    chk_all("abort_run", 1, 2'b01, 500, 480);
    step(3);                         // E128
    chk_all("abort_ramp", 1, 2'b01, 600, 580);
    step(8);                         // E136
    chk_all("abort_full", 1, 2'b01, 800, 780);

    // Stop: ramp down in RUN, bridge off only on IDLE entry.
    bus.mode = 3'b000;
    step(4);                         // E140
    chk_all("stop1", 1, 2'b01, 700, 680);
    step(24);                        // E164
    chk_all("stop7", 1, 2'b01, 100, 80);
    step(4);                         // E168
    chk_all("stop_idle", 0, 0, 0, 0);
    step(1);                         // E169
    chk("stop_idle.busy", 32'(bus.busy), 0);

    // Mid-cycle asynchronous reset with duties nonzero.
    bus.mode = 3'b001;
    step(1);                         // E170
    chk("restart.state", 32'(bus.state), 1);
    step(6);                         // E176 (ticks at E172, E176)
    chk("restart.left", 32'(bus.left_duty), 200);
    #3;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0);
    chk("async_rst.busy", 32'(bus.busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net: the directed sequence is far shorter than this.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/motor_ramp_ctrl.md
Name: motor_ramp_ctrl

Overview:
- Sequences the two-motor PWM datapath.
- Takes a 3-bit drive mode request and produces slew-limited 10-bit duty values plus H-bridge direction codes for the left and right motors.
- Reversing direction goes through a controlled brake-to-zero and a dead-time with both bridges off.
- Sits between the kart's mode/decision logic and the per-motor PWM generators, which run at 100 MHz with a 1024-step duty scale.

Parameters:
- TICK_DIV, 100000: clk cycles per ramp tick (1 ms at 100 MHz).
- STEP, 16: maximum duty change per tick, applied per motor.
- DEAD_TICKS, 50: number of ticks with both bridges off between a direction reversal's brake and its re-drive.
- DUTY_HI, 800: duty of the faster wheel.
- DUTY_TRIM, 780: right-wheel duty in straight modes.
- DUTY_LO, 750: duty of the slower wheel in turns.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- mode  in  3  drive request, sampled every cycle.
- left_duty  out  10  left PWM duty, registered.
- right_duty  out  10  right PWM duty, registered.
- l_IN  out  2  left H-bridge code, registered.
- r_IN  out  2  right H-bridge code, registered.
- busy  out  1  high while any duty is not at its target, or while in BRAKE or DEAD.
- state  out  2  debug state code: IDLE=0, RUN=1, BRAKE=2, DEAD=3.

Behaviour:
- Reset is asynchronous and active-high. While rst is high, the outputs are:
  - left_duty=0, right_duty=0
  - l_IN=r_IN=2'b00
  - busy=0, state=IDLE
  - tick counter=0, dead counter=0
- Mode decode (mode[2]=1 selects reverse), giving dir_req and left/right targets:
  - 000, 100: dir_req=NONE, targets 0/0.
  - 001, 101: dir_req=FWD for 001 and REV for 101; targets DUTY_HI/DUTY_TRIM.
  - 010, 110: dir_req=FWD/REV; targets DUTY_LO/DUTY_HI (left turn).
  - 011, 111: dir_req=FWD/REV; targets DUTY_HI/DUTY_LO (right turn).
- Tick counter:
  - Free-runs 0..TICK_DIV-1.
  - tick=1 for the single cycle when the count equals TICK_DIV-1; the counter then wraps to 0.
- Slew rule, applied on tick only, to each motor independently:
  - If duty<target: duty += min(STEP, target-duty).
  - If duty>target: duty -= min(STEP, duty-target).
  - Never overshoots; no wrap-around, since the arithmetic is 10-bit unsigned and uses the difference form.
- Latched direction dir (FWD/REV) sets the bridge codes:
  - In RUN and BRAKE: l_IN=r_IN=2'b10 for FWD, 2'b01 for REV.
  - In IDLE and DEAD: l_IN=r_IN=2'b00.
- State machine (transitions take effect on the next clk edge):
  - IDLE:
    - Duties are held at 0.
    - If dir_req!=NONE: latch dir=dir_req and go to RUN.
    - The bridge code is valid on the first RUN cycle; duties start ramping on the first tick after that.
  - RUN:
    - If dir_req==dir: slew toward the decoded targets.
    - If dir_req==NONE: slew toward 0/0. When both duties are 0 at the end of a tick update, go to IDLE.
    - If dir_req is the opposite of dir: go to BRAKE.
  - BRAKE:
    - Slew toward 0/0 with dir unchanged.
    - If dir_req returns to dir before both duties reach 0: go back to RUN.
    - When both duties reach 0: go to DEAD and load the dead counter with DEAD_TICKS.
  - DEAD:
    - Duties are 0; decrement the dead counter on each tick.
    - When the counter reaches 0: if dir_req==NONE go to IDLE; otherwise latch dir=dir_req and go to RUN.
- Simultaneous events:
  - A mode change on a tick cycle updates state and targets with the new decode, and the slew step in that cycle uses the new targets.
  - An opposite-direction request arriving in DEAD only affects the dir latched at DEAD exit.
- busy = (state==BRAKE) || (state==DEAD) || (state==RUN && (left_duty!=left target || right_duty!=right target)).
- Invariants:
  - l_IN/r_IN never switch directly between 10 and 01; a direction change always passes through at least DEAD_TICKS ticks of 00.
  - A duty is never nonzero while its bridge code is 00.

Test Plan (TICK_DIV=4, STEP=100, DEAD_TICKS=2, DUTY_HI=800, DUTY_TRIM=780, DUTY_LO=750):
1. Reset: assert rst mid-cycle → duties 0, IN=00, state=0, busy=0 immediately, without waiting for a clk edge.
2. Start forward: mode=001 from IDLE → next cycle state=RUN, IN=10.
   - Left steps 100,200,…,800 on successive ticks (every 4 clks).
   - Right steps 100,…,700,780 (last step 80).
   - busy falls on the cycle after right reaches 780.
3. Turn at speed: steady 800/780, mode=010 → on the next tick left=750 (step 50), right=800 (step 20); state stays RUN and IN stays 10.
4. Reverse: steady forward 800/780, mode=101 → state=BRAKE with IN still 10.
   - Duties ramp down to 0 over 8 ticks.
   - Then DEAD with IN=00 for 2 ticks.
   - Then RUN with IN=01, ramping to 800/780; IN is never 01 while a duty is nonzero under 10.
5. Abort brake: during BRAKE at 500/480, mode back to 001 → next cycle state=RUN, IN=10; duties ramp up from 500/480 with no dead time.
6. Stop: steady forward, mode=000 → RUN ramps down to 0/0 and then goes to IDLE; IN changes to 00 only on entry to IDLE.
